axis_user_router: RTL and testbench
===================================

AXIS_USER_ROUTER -- requirements
Module: axis_user_router

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 4, meaning number of output streams, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning tdata width in bits.
REQ-003 SHALL have parameter USER_WIDTH, default 2, meaning tuser width in bits, at least clog2(MASTER_NUM).
REQ-004 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rstn_i  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port s_axis_tvalid  in  1  input beat valid.
REQ-007 SHALL have port s_axis_tready  out  1  input beat accepted.
REQ-008 SHALL have port s_axis_tdata  in  DATA_WIDTH  input payload.
REQ-009 SHALL have port s_axis_tuser  in  USER_WIDTH  destination index; the source tag from the upstream round-robin arbiter.
REQ-010 SHALL have port m_axis_tvalid  out  MASTER_NUM  per-output valid.
REQ-011 SHALL have port m_axis_tready  in  MASTER_NUM  per-output ready.
REQ-012 SHALL have port m_axis_tdata  out  MASTER_NUM x DATA_WIDTH  per-output payload.
REQ-013 SHALL have port beat_cnt_o  out  MASTER_NUM x 32  per-output delivered-beat count.
REQ-014 SHALL have port drop_cnt_o  out  32  count of dropped out-of-range beats.

Function
REQ-015 SHALL accept an input beat when s_axis_tvalid and s_axis_tready are both high in the same cycle.
REQ-016 SHALL give each output a 2-entry in-order buffer with states EMPTY, ONE and TWO.
REQ-017 SHALL drive s_axis_tready high when tuser >= MASTER_NUM, or when the buffer of output tuser is not in TWO; this is combinational from tuser and registered state only, and never depends on m_axis_tready.
REQ-018 SHALL present an accepted in-range beat on m_axis_tvalid[tuser] and m_axis_tdata[tuser] on the next cycle when that buffer was EMPTY (latency 1).
REQ-019 SHALL pop an output on m_axis_tvalid[k] & m_axis_tready[k].
REQ-020 SHALL apply these buffer transitions:
- push only: EMPTY->ONE, ONE->TWO.
- pop only: TWO->ONE, ONE->EMPTY.
- push and pop together: state unchanged; the head is replaced by the next-oldest beat.
REQ-021 SHALL sustain one beat per cycle per output when ready is held high.
REQ-022 SHALL drive m_axis_tvalid[k] high exactly when buffer k is not EMPTY, and hold m_axis_tdata[k] stable while valid is high and ready is low.
REQ-023 SHALL, when tuser >= MASTER_NUM, accept the beat, discard it and route it to no output.
REQ-024 SHALL keep the outputs independent: a stalled output blocks input only while the input is addressed to it.
REQ-025 SHALL preserve per-output beat ordering.

Reset
REQ-026 SHALL, when rstn_i is low, asynchronously force all buffers to EMPTY, m_axis_tvalid to 0, m_axis_tdata to 0 and all counters to 0.
REQ-027 SHALL discard buffered beats on reset mid-operation.
REQ-028 SHALL hold s_axis_tready at 0 while rstn_i is low.

Configuration
REQ-029 SHALL use macro AXIS_USER_ROUTER_CNT_EN.
REQ-030 SHALL, when the macro is defined:
- increment beat_cnt_o[k] on each pop of output k.
- increment drop_cnt_o on each dropped beat.
- wrap both counters modulo 2^32.
REQ-031 SHALL, when the macro is undefined, keep all counter ports present, tie them to 0 and infer no counter flops.

Verification
REQ-032 SHALL cover: input 0xA5A5, tuser=2, m_axis_tready all high -> m_axis_tvalid=4'b0100 with tdata[2]=0xA5A5 exactly 1 cycle later, then 0 the following cycle.
REQ-033 SHALL cover: m_axis_tready[1]=0 and three beats 0x1,0x2,0x3 to tuser=1 -> s_axis_tready drops after 2 accepts; releasing ready delivers 0x1,0x2,0x3 in order.
REQ-034 SHALL cover: output 1 full, then a beat with tuser=3 -> accepted immediately and delivered on output 3 while output 1 stays full.
REQ-035 SHALL cover: MASTER_NUM=3, USER_WIDTH=2, beat with tuser=3 -> accepted, no m_axis_tvalid, drop_cnt_o=1 with AXIS_USER_ROUTER_CNT_EN defined, 0 without.
REQ-036 SHALL cover: output 0 in state TWO, assert rstn_i=0 asynchronously mid-cycle -> m_axis_tvalid=0 immediately; after release, s_axis_tready=1 and no stale beat appears.
REQ-037 SHALL cover: 1000 back-to-back beats to tuser=0 with ready high -> one beat per cycle, beat_cnt_o[0]=1000 with macro defined.

Source files
------------

// File: rtl/axis_user_router.sv
// AXI-Stream router: steers each input beat to output s_axis_tuser through a 2-deep per-output buffer.
// Optional AXIS_USER_ROUTER_CNT_EN adds per-output delivered-beat counters and a dropped-beat counter.
module axis_user_router #(
  parameter int MASTER_NUM = 4,
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [MASTER_NUM-1:0]            m_axis_tvalid,
  input  logic [MASTER_NUM-1:0]            m_axis_tready,
  output logic [MASTER_NUM*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [MASTER_NUM*32-1:0]         beat_cnt_o,
  output logic [31:0]                      drop_cnt_o
);

  // state | meaning
  // EMPTY | no beat held, output valid low
  // ONE   | head holds one beat
  // TWO   | head and tail both hold beats, destination blocks input
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  logic [MASTER_NUM-1:0] w_sel;
  logic [MASTER_NUM-1:0] w_full;
  logic [MASTER_NUM-1:0] w_push;
  logic [MASTER_NUM-1:0] w_pop;
  logic                  w_accept;

  // Ready never looks at m_axis_tready, so the input path has no comb loop through the outputs.
  assign s_axis_tready = rstn_i & ~(|(w_sel & w_full));
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_push        = w_sel & {MASTER_NUM{w_accept}};
  assign w_pop         = m_axis_tvalid & m_axis_tready;

  for (genvar k = 0; k < MASTER_NUM; k++) begin : g_out
    buf_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    assign w_sel[k]                                = (s_axis_tuser == USER_WIDTH'(k));
    assign w_full[k]                               = (r_state == ST_TWO);
    assign m_axis_tvalid[k]                        = (r_state != ST_EMPTY);
    assign m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] = r_head;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_state <= ST_EMPTY;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_push[k]) begin
              r_head  <= s_axis_tdata;
              r_state <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_push[k] && w_pop[k]) begin
              r_head <= s_axis_tdata;
            end else if (w_push[k]) begin
              r_tail  <= s_axis_tdata;
              r_state <= ST_TWO;
            end else if (w_pop[k]) begin
              r_state <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (w_pop[k]) begin
              r_head  <= r_tail;
              r_state <= ST_ONE;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end

`ifdef AXIS_USER_ROUTER_CNT_EN
    logic [31:0] r_beat_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_beat_cnt <= '0;
      end else if (w_pop[k]) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
    end

    assign beat_cnt_o[k*32 +: 32] = r_beat_cnt;
`endif
  end

`ifdef AXIS_USER_ROUTER_CNT_EN
  logic        w_drop;
  logic [31:0] r_drop_cnt;

  // No select bit set means tuser addresses a nonexistent output.
  assign w_drop = w_accept & ~(|w_sel);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign drop_cnt_o = r_drop_cnt;
`else
  assign beat_cnt_o = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axis_user_router.sv
// Bench for axis_user_router: directed scenarios plus random traffic against a per-output FIFO model.
module tb_axis_user_router;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_tready;
  logic [15:0] s_data;
  logic [1:0]  s_user;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_ready;
  logic [63:0] m_tdata;
  logic [127:0] beat_cnt;
  logic [31:0] drop_cnt;

  logic        s3_valid;
  logic        s3_tready;
  logic [15:0] s3_data;
  logic [1:0]  s3_user;
  logic [2:0]  m3_tvalid;
  logic [2:0]  m3_ready;
  logic [47:0] m3_tdata;
  logic [95:0] beat3_cnt;
  logic [31:0] drop3_cnt;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mq [4][2];
  int          mn [4];
  int          bc [4];
  logic        last_acc;

  always #5 clk = ~clk;

  axis_user_router #(.MASTER_NUM(4), .DATA_WIDTH(16), .USER_WIDTH(2)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_data), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_ready), .m_axis_tdata(m_tdata),
    .beat_cnt_o(beat_cnt), .drop_cnt_o(drop_cnt)
  );

  axis_user_router #(.MASTER_NUM(3), .DATA_WIDTH(16), .USER_WIDTH(2)) dut3 (
    .clk_i(clk), .rstn_i(rstn),
    .s_axis_tvalid(s3_valid), .s_axis_tready(s3_tready),
    .s_axis_tdata(s3_data), .s_axis_tuser(s3_user),
    .m_axis_tvalid(m3_tvalid), .m_axis_tready(m3_ready), .m_axis_tdata(m3_tdata),
    .beat_cnt_o(beat3_cnt), .drop_cnt_o(drop3_cnt)
  );

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef AXIS_USER_ROUTER_CNT_EN
    return 32'(n);
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mn[k] = 0;
      bc[k] = 0;
    end
  endtask

  // One clock: check outputs against the model at negedge, then advance the model to the next edge.
  task automatic cycle();
    int         u;
    logic       rdy_e;
    logic [3:0] v_e;
    @(negedge clk);
    u     = int'(s_user);
    rdy_e = (mn[u] < 2);
    chk("s_tready", 64'(s_tready), 64'(rdy_e));
    for (int k = 0; k < 4; k++) v_e[k] = (mn[k] > 0);
    chk("m_tvalid", 64'(m_tvalid), 64'(v_e));
    for (int k = 0; k < 4; k++) begin
      if (mn[k] > 0) chk($sformatf("m_tdata%0d", k), 64'(m_tdata[k*16 +: 16]), 64'(mq[k][0]));
      chk($sformatf("beat_cnt%0d", k), 64'(beat_cnt[k*32 +: 32]), 64'(exp_cnt(bc[k])));
    end
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_cnt(0)));
    last_acc = s_valid && rdy_e;
    for (int k = 0; k < 4; k++) begin
      if (mn[k] > 0 && m_ready[k]) begin
        mq[k][0] = mq[k][1];
        mn[k]--;
        bc[k]++;
      end
    end
    if (last_acc) begin
      mq[u][mn[u]] = s_data;
      mn[u]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_n;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_user   = '0;
    m_ready  = '0;
    s3_valid = 1'b0;
    s3_data  = '0;
    s3_user  = '0;
    m3_ready = 3'b111;
    last_acc = 1'b0;
    model_clear();

    // reset state
    #12;
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tdata", m_tdata, 64'(0));
    chk("rst_beat", 64'(beat_cnt[63:0]), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    chk("rst_tready3", 64'(s3_tready), 64'(0));
    @(posedge clk);
    #1 rstn = 1'b1;

    // single beat to output 2, one-cycle latency
    m_ready = 4'hF;
    s_valid = 1'b1; s_user = 2'd2; s_data = 16'hA5A5;
    cycle();
    s_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", 64'(m_tvalid), 64'(4'b0100));
    chk("lat1_data", 64'(m_tdata[47:32]), 64'(16'hA5A5));
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) mn[k] = 0;
    bc[2] = 1;
    cycle();

    // stalled output 1 fills after two beats
    m_ready = 4'b1101;
    s_user  = 2'd1;
    acc_n   = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(acc_n + 1);
      cycle();
      if (last_acc) acc_n++;
    end
    chk("stall_accepts", 64'(acc_n), 64'(2));

    // other destination still flows while output 1 is full
    s_user = 2'd3; s_data = 16'h0333;
    cycle();
    chk("bypass_acc", 64'(last_acc), 64'(1));
    s_valid = 1'b0;
    @(negedge clk);
    chk("bypass_out3", 64'(m_tvalid), 64'(4'b1010));
    chk("bypass_data3", 64'(m_tdata[63:48]), 64'(16'h0333));
    @(posedge clk); #1;
    mq[3][0] = mq[3][1]; mn[3] = 0; bc[3]++;

    // release output 1 and deliver the third beat
    m_ready = 4'hF;
    s_valid = 1'b1; s_user = 2'd1; s_data = 16'h0003;
    for (int i = 0; i < 6 && acc_n < 3; i++) begin
      cycle();
      if (last_acc) acc_n++;
    end
    chk("order_accepts", 64'(acc_n), 64'(3));
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // asynchronous reset while output 0 holds two beats
    m_ready = 4'b1110;
    s_valid = 1'b1; s_user = 2'd0; s_data = 16'h0011;
    cycle();
    s_data = 16'h0022;
    cycle();
    s_valid = 1'b0;
    chk("pre_rst_full", 64'(mn[0]), 64'(2));
    #2 rstn = 1'b0;
    #1;
    chk("async_tvalid", 64'(m_tvalid), 64'(0));
    chk("async_tready", 64'(s_tready), 64'(0));
    chk("async_tdata", m_tdata, 64'(0));
    model_clear();
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    m_ready = 4'hF;
    for (int i = 0; i < 3; i++) cycle();

    // 1000 back-to-back beats to output 0
    acc_n   = 0;
    s_valid = 1'b1; s_user = 2'd0;
    for (int i = 0; i < 1000; i++) begin
      s_data = 16'(i);
      cycle();
      if (last_acc) acc_n++;
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("b2b_accepts", 64'(acc_n), 64'(1000));
    chk("b2b_beat_cnt0", 64'(beat_cnt[31:0]), 64'(exp_cnt(1000)));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_user  = 2'($urandom_range(0, 3));
      s_data  = 16'($urandom);
      m_ready = 4'($urandom);
      cycle();
    end
    s_valid = 1'b0;
    m_ready = 4'hF;
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", 64'(m_tvalid), 64'(0));

    // out-of-range tuser on the 3-output instance is dropped
    s3_valid = 1'b1; s3_user = 2'd3; s3_data = 16'hBEEF;
    @(negedge clk);
    chk("drop_tready3", 64'(s3_tready), 64'(1));
    @(posedge clk); #1;
    s3_valid = 1'b0;
    @(negedge clk);
    chk("drop_tvalid3", 64'(m3_tvalid), 64'(0));
    chk("drop_cnt3", 64'(drop3_cnt), 64'(exp_cnt(1)));
    chk("drop_beat3", 64'(beat3_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
